// File: rtl/sprite_anim_renderer.sv
// sprite_anim_renderer: animated, scalable, flippable sprite renderer feeding a synchronous sprite ROM
module sprite_anim_renderer #(
    parameter int SPRITE_W     = 40,
    parameter int SPRITE_H     = 50,
    parameter int NUM_FRAMES   = 4,
    parameter int FRAME_TICKS  = 8,
    parameter int SCALE_SHIFT  = 0,
    parameter int INDEX_W      = 3,
    parameter int TRANSP_EN    = 1,
    parameter int TRANSP_INDEX = 0,
    parameter int ADDR_W       = $clog2(SPRITE_W*SPRITE_H*NUM_FRAMES),
    parameter int FRAME_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic [9:0]         CharX,
    input  logic [9:0]         CharY,
    input  logic               frame_tick,
    input  logic               flip_h,
    input  logic               anim_start,
    input  logic               anim_loop,
    input  logic               anim_stop,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INDEX_W-1:0] rom_data,
    output logic [INDEX_W-1:0] pix_index,
    output logic               active,
    output logic [FRAME_W-1:0] frame_idx,
    output logic               anim_busy,
    output logic               anim_done
);
    localparam int BW     = SPRITE_W << SCALE_SHIFT;
    localparam int BH     = SPRITE_H << SCALE_SHIFT;
    localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, LOOP, ONESHOT, HOLD} state_t;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [FRAME_W-1:0] frame_q, frame_d, frame_nx;
    logic               done_d, done_q;
    logic [9:0]         lx_q, ly_q, sx, sy, xe;
    logic               lflip_q, lvalid_q, in_box, flag_q;
    logic [INDEX_W-1:0] pix_q;
    logic               act_q;

    // lvalid_q keeps the sprite dark after reset until a real position has been latched
    assign in_box = lvalid_q
                 && {1'b0, DrawX} >= {1'b0, lx_q} && {1'b0, DrawX} < {1'b0, lx_q} + 11'(BW)
                 && {1'b0, DrawY} >= {1'b0, ly_q} && {1'b0, DrawY} < {1'b0, ly_q} + 11'(BH);
    assign sx = (DrawX - lx_q) >> SCALE_SHIFT;
    assign sy = (DrawY - ly_q) >> SCALE_SHIFT;
    assign xe = lflip_q ? 10'(SPRITE_W - 1) - sx : sx;
    assign rom_addr = in_box ? ADDR_W'(frame_q) * ADDR_W'(SPRITE_W*SPRITE_H)
                             + ADDR_W'(sy) * ADDR_W'(SPRITE_W) + ADDR_W'(xe) : '0;
    assign pix_index = pix_q;
    assign active    = act_q;
    assign frame_idx = frame_q;
    assign anim_busy = (state_q == LOOP) || (state_q == ONESHOT);
    assign anim_done = done_q;
    assign frame_nx  = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;

    // Capture position and flip once per video frame so a frame never tears
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            lx_q     <= '0;
            ly_q     <= '0;
            lflip_q  <= 1'b0;
            lvalid_q <= 1'b0;
        end else if (frame_tick) begin
            lx_q     <= CharX;
            ly_q     <= CharY;
            lflip_q  <= flip_h;
            lvalid_q <= 1'b1;
        end
    end

    // Two-stage pixel pipeline aligned with the one-cycle ROM read
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_q <= 1'b0;
            pix_q  <= '0;
            act_q  <= 1'b0;
        end else begin
            flag_q <= in_box && blank;
            pix_q  <= flag_q ? rom_data : '0;
            act_q  <= flag_q && !((TRANSP_EN != 0) && rom_data == INDEX_W'(TRANSP_INDEX));
        end
    end

    // Animation state register
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            frame_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    // Animation next state: start beats stop, and a restart swallows a coincident tick
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        if (anim_start) begin
            state_d = anim_loop ? LOOP : ONESHOT;
            tick_d  = '0;
            frame_d = '0;
        end else if (anim_stop) begin
            state_d = IDLE;
            tick_d  = '0;
            frame_d = '0;
        end else if (frame_tick && (state_q == LOOP || state_q == ONESHOT)) begin
            if (tick_q == TICK_W'(FRAME_TICKS - 1)) begin
                tick_d  = '0;
                frame_d = frame_nx;
                if (state_q == ONESHOT && frame_nx == FRAME_W'(NUM_FRAMES - 1)) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                end
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sprite_anim_renderer.sv
// tb_sprite_anim_renderer: directed checks of geometry, pipeline, flip, scale and animation
module tb_sprite_anim_renderer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  draw_x = '0, draw_y = '0, char_x = '0, char_y = '0;
    logic        blank = 1'b1, frame_tick = 1'b0, flip_h = 1'b0;
    logic        anim_start = 1'b0, anim_loop = 1'b0, anim_stop = 1'b0;
    logic        force_en = 1'b0;
    logic [2:0]  force_val = '0;
    logic [12:0] ra0, ra1;
    logic [2:0]  rd0 = '0, rd1 = '0, p0, p1;
    logic        a0, a1, b0, b1, d0, d1;
    logic [1:0]  f0, f1;
    int          vectors = 0, errors = 0;

    always #5 clk = ~clk;

    // ROM model: palette index is the low three address bits unless overridden
    always @(posedge clk) begin
        rd0 <= force_en ? force_val : ra0[2:0];
        rd1 <= force_en ? force_val : ra1[2:0];
    end

    sprite_anim_renderer dut0 (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
        .CharX(char_x), .CharY(char_y), .frame_tick(frame_tick), .flip_h(flip_h),
        .anim_start(anim_start), .anim_loop(anim_loop), .anim_stop(anim_stop),
        .rom_addr(ra0), .rom_data(rd0), .pix_index(p0), .active(a0),
        .frame_idx(f0), .anim_busy(b0), .anim_done(d0)
    );

    sprite_anim_renderer #(.SCALE_SHIFT(1), .FRAME_TICKS(2)) dut1 (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
        .CharX(char_x), .CharY(char_y), .frame_tick(frame_tick), .flip_h(flip_h),
        .anim_start(anim_start), .anim_loop(anim_loop), .anim_stop(anim_stop),
        .rom_addr(ra1), .rom_data(rd1), .pix_index(p1), .active(a1),
        .frame_idx(f1), .anim_busy(b1), .anim_done(d1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic at(input int x, input int y);
        draw_x = 10'(x);
        draw_y = 10'(y);
        #1;
    endtask

    task automatic test_reset();
        at(5, 5);
        vectors++; if (a0 !== 1'b0) begin errors++; $display("FAIL reset_active got %0d exp 0", a0); end
        vectors++; if (p0 !== 3'd0) begin errors++; $display("FAIL reset_pix got %0d exp 0", p0); end
        vectors++; if (f0 !== 2'd0 || b0 !== 1'b0 || d0 !== 1'b0) begin errors++; $display("FAIL reset_anim got f%0d b%0d d%0d exp 0", f0, b0, d0); end
        vectors++; if (ra0 !== 13'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", ra0); end
        step();
        rst_n = 1'b1;
        step(); step(); step();
        vectors++; if (a0 !== 1'b0 || a1 !== 1'b0) begin errors++; $display("FAIL unlatched_active got %0d/%0d exp 0", a0, a1); end
    endtask

    task automatic test_basic();
        char_x = 10'd100; char_y = 10'd50; flip_h = 1'b0;
        tick();
        at(100, 50);
        vectors++; if (ra0 !== 13'd0) begin errors++; $display("FAIL addr_100 got %0d exp 0", ra0); end
        at(139, 50);
        vectors++; if (ra0 !== 13'd39) begin errors++; $display("FAIL addr_139 got %0d exp 39", ra0); end
        step(); step();
        vectors++; if (a0 !== 1'b1 || p0 !== 3'd7) begin errors++; $display("FAIL pix_139 got a%0d p%0d exp a1 p7", a0, p0); end
        at(101, 51);
        vectors++; if (ra0 !== 13'd41) begin errors++; $display("FAIL addr_101_51 got %0d exp 41", ra0); end
        step(); step();
        vectors++; if (a0 !== 1'b1 || p0 !== 3'd1) begin errors++; $display("FAIL pix_101_51 got a%0d p%0d exp a1 p1", a0, p0); end
        at(140, 50);
        vectors++; if (ra0 !== 13'd0) begin errors++; $display("FAIL addr_140 got %0d exp 0", ra0); end
        step(); step();
        vectors++; if (a0 !== 1'b0 || p0 !== 3'd0) begin errors++; $display("FAIL pix_140 got a%0d p%0d exp 0", a0, p0); end
        at(99, 50); step(); step();
        vectors++; if (a0 !== 1'b0) begin errors++; $display("FAIL pix_99 got %0d exp 0", a0); end
        at(100, 50); step(); step();
        vectors++; if (a0 !== 1'b0 || p0 !== 3'd0) begin errors++; $display("FAIL transp_100 got a%0d p%0d exp 0", a0, p0); end
        at(101, 50); blank = 1'b0; step(); step();
        vectors++; if (a0 !== 1'b0) begin errors++; $display("FAIL blanked got %0d exp 0", a0); end
        blank = 1'b1;
    endtask

    task automatic test_flip();
        flip_h = 1'b1;
        tick();
        at(100, 51);
        vectors++; if (ra0 !== 13'd79) begin errors++; $display("FAIL flip_addr got %0d exp 79", ra0); end
        flip_h = 1'b0;
        step();
        vectors++; if (ra0 !== 13'd79) begin errors++; $display("FAIL flip_hold got %0d exp 79", ra0); end
        at(139, 51);
        vectors++; if (ra0 !== 13'd40) begin errors++; $display("FAIL flip_right got %0d exp 40", ra0); end
        tick();
        vectors++; if (ra0 !== 13'd79) begin errors++; $display("FAIL unflip got %0d exp 79", ra0); end
    endtask

    task automatic test_scale();
        char_x = 10'd0; char_y = 10'd0;
        tick();
        at(0, 0);
        vectors++; if (ra1 !== 13'd0) begin errors++; $display("FAIL scale_x0 got %0d exp 0", ra1); end
        at(1, 0);
        vectors++; if (ra1 !== 13'd0) begin errors++; $display("FAIL scale_x1 got %0d exp 0", ra1); end
        at(79, 0);
        vectors++; if (ra1 !== 13'd39) begin errors++; $display("FAIL scale_x79 got %0d exp 39", ra1); end
        at(0, 99);
        vectors++; if (ra1 !== 13'd1960) begin errors++; $display("FAIL scale_y99 got %0d exp 1960", ra1); end
        at(2, 0); step(); step();
        vectors++; if (a1 !== 1'b1 || p1 !== 3'd1) begin errors++; $display("FAIL scale_pix2 got a%0d p%0d exp a1 p1", a1, p1); end
        at(80, 0);
        vectors++; if (ra1 !== 13'd0) begin errors++; $display("FAIL scale_x80_addr got %0d exp 0", ra1); end
        step(); step();
        vectors++; if (a1 !== 1'b0) begin errors++; $display("FAIL scale_x80_act got %0d exp 0", a1); end
        at(0, 100); step(); step();
        vectors++; if (a1 !== 1'b0) begin errors++; $display("FAIL scale_y100_act got %0d exp 0", a1); end
    endtask

    task automatic test_loop();
        logic [1:0] exp_f [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        at(0, 0);
        anim_start = 1'b1; anim_loop = 1'b1;
        step();
        anim_start = 1'b0;
        vectors++; if (f1 !== 2'd0 || b1 !== 1'b1) begin errors++; $display("FAIL loop_start got f%0d b%0d exp f0 b1", f1, b1); end
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++; if (f1 !== exp_f[i]) begin errors++; $display("FAIL loop_tick%0d got %0d exp %0d", i + 1, f1, exp_f[i]); end
            if (i == 3) begin
                vectors++; if (ra1 !== 13'd4000) begin errors++; $display("FAIL frame2_addr got %0d exp 4000", ra1); end
            end
            step();
        end
        tick();
        anim_start = 1'b1; frame_tick = 1'b1;
        step();
        anim_start = 1'b0; frame_tick = 1'b0;
        vectors++; if (f1 !== 2'd0) begin errors++; $display("FAIL restart_tick got %0d exp 0", f1); end
        tick();
        vectors++; if (f1 !== 2'd0) begin errors++; $display("FAIL restart_tick1 got %0d exp 0", f1); end
        tick();
        vectors++; if (f1 !== 2'd1) begin errors++; $display("FAIL restart_tick2 got %0d exp 1", f1); end
        anim_stop = 1'b1;
        step();
        anim_stop = 1'b0;
        vectors++; if (f1 !== 2'd0 || b1 !== 1'b0) begin errors++; $display("FAIL stop got f%0d b%0d exp 0", f1, b1); end
    endtask

    task automatic test_oneshot();
        int dones = 0;
        int done_at = -1;
        logic [1:0] done_f = '0;
        anim_start = 1'b1; anim_loop = 1'b0;
        step();
        anim_start = 1'b0;
        vectors++; if (b0 !== 1'b1 || f0 !== 2'd0) begin errors++; $display("FAIL oneshot_start got b%0d f%0d exp b1 f0", b0, f0); end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (d0) begin dones++; done_at = i; done_f = f0; end
            step();
            if (d0) dones++;
        end
        vectors++; if (dones !== 1) begin errors++; $display("FAIL done_count got %0d exp 1", dones); end
        vectors++; if (done_at !== 23 || done_f !== 2'd3) begin errors++; $display("FAIL done_when got tick%0d f%0d exp tick23 f3", done_at, done_f); end
        vectors++; if (f0 !== 2'd3 || b0 !== 1'b0) begin errors++; $display("FAIL hold got f%0d b%0d exp f3 b0", f0, b0); end
        anim_start = 1'b1; anim_stop = 1'b1;
        step();
        anim_start = 1'b0; anim_stop = 1'b0;
        vectors++; if (f0 !== 2'd0 || b0 !== 1'b1) begin errors++; $display("FAIL start_beats_stop got f%0d b%0d exp f0 b1", f0, b0); end
    endtask

    task automatic test_edges();
        char_x = 10'd1000; char_y = 10'd0;
        tick();
        for (int x = 0; x < 16; x++) begin
            at(x, 0);
            vectors++; if (ra0 !== 13'd0) begin errors++; $display("FAIL nowrap_x%0d got %0d exp 0", x, ra0); end
        end
        step(); step();
        vectors++; if (a0 !== 1'b0) begin errors++; $display("FAIL nowrap_act got %0d exp 0", a0); end
        at(1010, 0);
        vectors++; if (ra0 !== 13'd10) begin errors++; $display("FAIL far_addr got %0d exp 10", ra0); end
        force_en = 1'b1; force_val = 3'd0;
        step(); step();
        vectors++; if (a0 !== 1'b0 || p0 !== 3'd0) begin errors++; $display("FAIL forced_transp got a%0d p%0d exp 0", a0, p0); end
        force_val = 3'd5;
        step(); step();
        vectors++; if (a0 !== 1'b1 || p0 !== 3'd5) begin errors++; $display("FAIL forced_opaque got a%0d p%0d exp a1 p5", a0, p0); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (a0 !== 1'b0 || p0 !== 3'd0 || f0 !== 2'd0 || b0 !== 1'b0) begin errors++; $display("FAIL async_reset got a%0d p%0d f%0d b%0d exp 0", a0, p0, f0, b0); end
        step();
        rst_n = 1'b1;
        step(); step(); step();
        vectors++; if (a0 !== 1'b0) begin errors++; $display("FAIL post_reset_dark got %0d exp 0", a0); end
        force_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flip();
        test_scale();
        test_loop();
        test_oneshot();
        test_edges();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
